// File: rtl/cnn_pkg.sv
// Shared constants and pixel type for the CNN input pipeline.
package cnn_pkg;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned DATA_X    = 28;
    localparam int unsigned DATA_Y    = 28;
    localparam int unsigned PIX_N     = DATA_X * DATA_Y;
    localparam int unsigned AW        = $clog2(PIX_N);

    typedef logic [DATA_SIZE-1:0] pixel_t;

endpackage

// File: rtl/pixel_bank.sv
// One frame buffer: synchronous write port, registered read port that
// returns zero for addresses beyond the frame.
module pixel_bank import cnn_pkg::*; #(
    parameter int unsigned DW    = DATA_SIZE,
    parameter int unsigned DEPTH = PIX_N,
    parameter int unsigned AWID  = AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AWID-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [AWID-1:0] raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with out-of-range addresses reading as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (raddr < AWID'(DEPTH)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/image_loader.sv
// Ping-pong frame loader: fills one bank from the pixel stream while the
// convolution engine reads the other.
module image_loader #(
    parameter int unsigned DATA_SIZE = cnn_pkg::DATA_SIZE,
    parameter int unsigned DATA_X    = cnn_pkg::DATA_X,
    parameter int unsigned DATA_Y    = cnn_pkg::DATA_Y,
    parameter int unsigned PIX_N     = DATA_X * DATA_Y,
    parameter int unsigned AW        = $clog2(PIX_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 conv_start,
    output logic                 conv_busy,
    input  logic                 conv_done,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 frame_err,
    output logic [15:0]          frame_count
);

    typedef enum logic {W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} rstate_t;

    wstate_t              wstate;
    wstate_t              wstate_nxt;
    rstate_t              rstate;
    logic [1:0]           full;
    logic [1:0]           full_nxt;
    logic                 wr_bank;
    logic                 wr_bank_nxt;
    logic                 rd_bank;
    logic                 rd_sel;
    logic [AW-1:0]        wr_cnt;
    logic                 accept;
    logic                 at_end;
    logic                 good_end;
    logic                 early_last;
    logic                 miss_last;
    logic                 drop_end;
    logic                 release_rd;
    logic [DATA_SIZE-1:0] rdata0;
    logic [DATA_SIZE-1:0] rdata1;

    // Beat classification and next bank occupancy; completion and release
    // always touch different bits because a full bank is never written.
    always_comb begin
        accept      = in_valid & in_ready;
        at_end      = (wr_cnt == AW'(PIX_N - 1));
        good_end    = (wstate == W_FILL) & accept & at_end & in_last;
        early_last  = (wstate == W_FILL) & accept & ~at_end & in_last;
        miss_last   = (wstate == W_FILL) & accept & at_end & ~in_last;
        drop_end    = (wstate == W_DROP) & accept & in_last;
        release_rd  = (rstate == R_BUSY) & conv_done;
        full_nxt    = full;
        if (good_end) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (release_rd) begin
            full_nxt[rd_bank] = 1'b0;
        end
        wr_bank_nxt = wr_bank ^ good_end;
        wstate_nxt  = wstate;
        if (miss_last) begin
            wstate_nxt = W_DROP;
        end else if (drop_end) begin
            wstate_nxt = W_FILL;
        end
    end

    // Write FSM, bank occupancy, pixel counter and write-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= W_FILL;
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            wr_cnt      <= '0;
            in_ready    <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            wstate    <= wstate_nxt;
            full      <= full_nxt;
            wr_bank   <= wr_bank_nxt;
            in_ready  <= (wstate_nxt == W_DROP) | ~full_nxt[wr_bank_nxt];
            frame_err <= early_last | miss_last;
            if (good_end) begin
                frame_count <= frame_count + 16'd1;
            end
            if (good_end | early_last | miss_last) begin
                wr_cnt <= '0;
            end else if ((wstate == W_FILL) && accept) begin
                wr_cnt <= wr_cnt + AW'(1);
            end
        end
    end

    // Read FSM: announce a full bank, hold it until the engine releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate     <= R_IDLE;
            rd_bank    <= 1'b0;
            rd_sel     <= 1'b0;
            conv_start <= 1'b0;
            conv_busy  <= 1'b0;
        end else begin
            rd_sel     <= rd_bank;
            conv_start <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rstate     <= R_START;
                        conv_start <= 1'b1;
                    end
                end
                R_START: begin
                    rstate    <= R_BUSY;
                    conv_busy <= 1'b1;
                end
                R_BUSY: begin
                    if (conv_done) begin
                        rstate    <= R_IDLE;
                        conv_busy <= 1'b0;
                        rd_bank   <= ~rd_bank;
                    end
                end
                default: begin
                    rstate    <= R_IDLE;
                    conv_busy <= 1'b0;
                end
            endcase
        end
    end

    pixel_bank #(.DW(DATA_SIZE), .DEPTH(PIX_N), .AWID(AW)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    ((wstate == W_FILL) & accept & ~wr_bank),
        .waddr (wr_cnt),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    pixel_bank #(.DW(DATA_SIZE), .DEPTH(PIX_N), .AWID(AW)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    ((wstate == W_FILL) & accept & wr_bank),
        .waddr (wr_cnt),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // Select the registered read from the bank that was owned when the
    // address was sampled.
    assign rd_data = rd_sel ? rdata1 : rdata0;

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader against a frame-queue reference model.
module tb_image_loader;
    import cnn_pkg::*;

    typedef pixel_t frame_t [PIX_N];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    pixel_t        in_data = '0;
    logic          in_last = 1'b0;
    logic          conv_start;
    logic          conv_busy;
    logic          conv_done = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    pixel_t        rd_data;
    logic          frame_err;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    image_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .conv_start  (conv_start),
        .conv_busy   (conv_busy),
        .conv_done   (conv_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    // Reference model: completed frames waiting for / owned by the engine.
    frame_t      exp_q[$];
    pixel_t      cur[$];
    bit          dropping = 1'b0;
    int          m_err = 0;
    logic [15:0] m_fc = 16'd0;
    int          exp_starts = 0;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_err   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (conv_start === 1'b1) n_start++;
        if (frame_err === 1'b1) n_err++;
    end

    // Frame-level rules applied to every beat the DUT accepted.
    function automatic void model_beat(input pixel_t d, input logic last);
        frame_t f;
        if (dropping) begin
            if (last) dropping = 1'b0;
            return;
        end
        cur.push_back(d);
        if (cur.size() == PIX_N) begin
            if (last) begin
                foreach (f[i]) f[i] = cur[i];
                exp_q.push_back(f);
                m_fc++;
            end else begin
                m_err++;
                dropping = 1'b1;
            end
            cur.delete();
        end else if (last) begin
            m_err++;
            cur.delete();
        end
    endfunction

    // Present one beat until accepted; optionally raise conv_done on the
    // accepting edge.
    task automatic put_beat(input pixel_t d, input logic last, input bit done_too, output bit ok);
        logic rdy;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int n = 0; n < 3000; n++) begin
            rdy = in_ready;
            if (rdy && done_too) conv_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            conv_done = 1'b0;
            if (rdy === 1'b1) begin
                ok = 1'b1;
                model_beat(d, last);
                break;
            end
        end
        if (!ok) chk("beat_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_frame(input pixel_t base, input int nbeats, input int last_at, input bit done_on_last);
        bit ok;
        for (int i = 0; i < nbeats; i++) begin
            put_beat(base + pixel_t'(i), (i == last_at), done_on_last && (i == last_at), ok);
            if (!ok) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (done_on_last && exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // conv_start low now, high for exactly the next cycle, then busy.
    task automatic expect_start(input string tag);
        chk({tag, "_pre"}, 32'(conv_start), 32'd0);
        @(negedge clk);
        chk({tag, "_start"}, 32'(conv_start), 32'd1);
        @(negedge clk);
        chk({tag, "_one"}, 32'(conv_start), 32'd0);
        chk({tag, "_busy"}, 32'(conv_busy), 32'd1);
        exp_starts++;
    endtask

    task automatic check_addr(input int a);
        frame_t f;
        pixel_t e;
        rd_addr = AW'(a);
        @(negedge clk);
        if (a >= int'(PIX_N)) begin
            e = '0;
        end else if (exp_q.size() == 0) begin
            chk("rd_model_empty", 32'(exp_q.size()), 32'd1);
            return;
        end else begin
            f = exp_q[0];
            e = f[a];
        end
        chk("rd_data", rd_data, e);
    endtask

    task automatic check_reads(input int n);
        for (int i = 0; i < n; i++) check_addr(int'($urandom_range(0, PIX_N - 1)));
        check_addr(800);
    endtask

    task automatic release_bank();
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        conv_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_start", 32'(conv_start), 32'd0);
        chk("rst_busy", 32'(conv_busy), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        exp_q.delete();
        cur.delete();
        dropping = 1'b0;
        m_fc     = 16'd0;
        rst      = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic good_frame(input string tag);
        send_frame($urandom, PIX_N, PIX_N - 1, 1'b0);
        chk({tag, "_fc"}, 32'(frame_count), 32'(m_fc));
        expect_start(tag);
        check_addr(0);
        check_reads(4);
    endtask

    initial begin
        int e0;
        int s0;

        do_reset();

        // Single frame with in_data = index.
        send_frame('0, PIX_N, PIX_N - 1, 1'b0);
        chk("single_fc", 32'(frame_count), 32'd1);
        expect_start("single");
        check_addr(29);
        chk("single_px29", rd_data, 32'd29);
        check_addr(800);
        chk("single_oob", rd_data, 32'd0);
        check_reads(4);

        // Ping-pong: second frame fills the other bank, third must stall.
        send_frame($urandom, PIX_N, PIX_N - 1, 1'b0);
        chk("pp_fc", 32'(frame_count), 32'(m_fc));
        in_valid = 1'b1;
        in_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            chk("pp_stall", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_bank();
        chk("pp_ready_back", 32'(in_ready), 32'd1);
        expect_start("pp");
        check_addr(0);
        check_reads(3);

        // Last beat of the next frame coincides with release of the current.
        send_frame($urandom, PIX_N, PIX_N - 1, 1'b1);
        chk("simul_no_stall", 32'(in_ready), 32'd1);
        chk("simul_fc", 32'(frame_count), 32'(m_fc));
        expect_start("simul");
        check_reads(3);
        release_bank();

        // Early last.
        e0 = n_err;
        s0 = n_start;
        send_frame($urandom, 100, 99, 1'b0);
        chk("early_err", 32'(frame_err), 32'd1);
        repeat (3) @(negedge clk);
        chk("early_err_once", 32'(n_err - e0), 32'd1);
        chk("early_no_start", 32'(n_start - s0), 32'd0);
        chk("early_fc", 32'(frame_count), 32'(m_fc));
        good_frame("after_early");
        release_bank();

        // Missing last, then junk up to a last beat.
        e0 = n_err;
        send_frame($urandom, PIX_N, -1, 1'b0);
        chk("miss_err", 32'(frame_err), 32'd1);
        send_frame($urandom, 5, 4, 1'b0);
        repeat (2) @(negedge clk);
        chk("miss_err_once", 32'(n_err - e0), 32'd1);
        chk("miss_fc", 32'(frame_count), 32'(m_fc));
        good_frame("after_miss");
        release_bank();

        // Reset mid-frame, then reset while the engine owns a bank.
        send_frame($urandom, 401, -1, 1'b0);
        do_reset();
        good_frame("rst_mid");
        do_reset();
        good_frame("rst_busy");
        release_bank();

        repeat (3) @(negedge clk);
        chk("total_err", 32'(n_err), 32'(m_err));
        chk("total_start", 32'(n_start), 32'(exp_starts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
